// File: rtl/doodle_pkg.sv
// Shared definitions for the doodle game movers: screen defaults and the
// vertical motion state encoding.
package doodle_pkg;

   localparam int unsigned DEF_SCREEN_WIDTH  = 400;
   localparam int unsigned DEF_SCREEN_HEIGHT = 700;

   typedef enum logic [1:0] {
      RISE = 2'd0,
      FALL = 2'd1,
      DEAD = 2'd2
   } motion_state_t;

endpackage

// File: rtl/doodle_motion_controller_if.sv
// Game-step bus between the game logic / collision detector and the doodle
// motion controller.
interface doodle_motion_controller_if;

   logic        tick;
   logic        moveLeft;
   logic        moveRight;
   logic        hasCollide;
   logic [31:0] collisionY;
   logic [31:0] doodleX;
   logic [31:0] doodleY;
   logic        isFalling;
   logic        landed;
   logic        gameOver;

   modport master (
      output tick, moveLeft, moveRight, hasCollide, collisionY,
      input  doodleX, doodleY, isFalling, landed, gameOver
   );

   modport slave (
      input  tick, moveLeft, moveRight, hasCollide, collisionY,
      output doodleX, doodleY, isFalling, landed, gameOver
   );

endinterface

// File: rtl/doodle_x_wrap.sv
// Combinational next-x for a horizontal mover on a wrapping screen; shared by
// the doodle and later enemy/monster movers.
module doodle_x_wrap
   import doodle_pkg::*;
#(
   parameter int unsigned SCREEN_WIDTH = DEF_SCREEN_WIDTH,
   parameter int unsigned X_STEP       = 4
) (
   input  logic [31:0] x_i,
   input  logic        move_left_i,
   input  logic        move_right_i,
   output logic [31:0] x_o
);

   localparam logic [31:0] WIDTH = 32'(SCREEN_WIDTH);
   localparam logic [31:0] STEP  = 32'(X_STEP);

   logic [31:0] sum_right;

   always_comb begin
      sum_right = x_i + STEP;
      x_o       = x_i;
      if (move_right_i && !move_left_i) begin
         x_o = (sum_right >= WIDTH) ? sum_right - WIDTH : sum_right;
      end else if (move_left_i && !move_right_i) begin
         // Left wrap adds the width first so the subtraction never underflows.
         x_o = (x_i < STEP) ? x_i + WIDTH - STEP : x_i - STEP;
      end
   end

endmodule

// File: rtl/doodle_motion_controller.sv
// Doodle position owner: unit-step jump/fall sequencing, landing on collision,
// horizontal wrap motion and game-over when falling off the bottom.
//
//   state | meaning
//   RISE  | moving up one unit per tick for JUMP_HEIGHT ticks; collisions ignored
//   FALL  | moving down one unit per tick; a collision lands and starts a new jump
//   DEAD  | fell off the bottom at y = 0; everything frozen until rst
module doodle_motion_controller
   import doodle_pkg::*;
#(
   parameter int unsigned SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
   parameter int unsigned SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
   parameter int unsigned START_Y       = 100,
   parameter int unsigned JUMP_HEIGHT   = 150,
   parameter int unsigned X_STEP        = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   doodle_motion_controller_if.slave  bus
);

   if (JUMP_HEIGHT < 1 || X_STEP < 1 || X_STEP >= SCREEN_WIDTH || SCREEN_HEIGHT < 1) begin : g_param_check
      $error("doodle_motion_controller: invalid geometry parameters");
   end

   localparam logic [31:0] RISE_LAST = 32'(JUMP_HEIGHT - 1);

   motion_state_t state_q, state_d;
   logic [31:0]   rise_cnt_q, rise_cnt_d;
   logic [31:0]   x_q, x_d;
   logic [31:0]   y_q, y_d;
   logic          landed_q, landed_d;
   logic [31:0]   x_next;

   doodle_x_wrap #(
      .SCREEN_WIDTH (SCREEN_WIDTH),
      .X_STEP       (X_STEP)
   ) u_x_wrap (
      .x_i          (x_q),
      .move_left_i  (bus.moveLeft),
      .move_right_i (bus.moveRight),
      .x_o          (x_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RISE;
         rise_cnt_q <= '0;
         x_q        <= 32'(SCREEN_WIDTH / 2);
         y_q        <= 32'(START_Y);
         landed_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rise_cnt_q <= rise_cnt_d;
         x_q        <= x_d;
         y_q        <= y_d;
         landed_q   <= landed_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rise_cnt_d = rise_cnt_q;
      x_d        = x_q;
      y_d        = y_q;
      landed_d   = 1'b0;
      if (bus.tick) begin
         unique case (state_q)
            RISE: begin
               x_d = x_next;
               y_d = y_q + 32'd1;
               if (rise_cnt_q == RISE_LAST) begin
                  state_d    = FALL;
                  rise_cnt_d = '0;
               end else begin
                  rise_cnt_d = rise_cnt_q + 32'd1;
               end
            end
            FALL: begin
               x_d = x_next;
               // Landing beats death so a platform at y = 0 still catches the doodle.
               if (bus.hasCollide) begin
                  y_d        = bus.collisionY;
                  state_d    = RISE;
                  rise_cnt_d = '0;
                  landed_d   = 1'b1;
               end else if (y_q == 32'd0) begin
                  state_d = DEAD;
               end else begin
                  y_d = y_q - 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.doodleX   = x_q;
   assign bus.doodleY   = y_q;
   assign bus.isFalling = (state_q == FALL);
   assign bus.gameOver  = (state_q == DEAD);
   assign bus.landed    = landed_q;

endmodule

// File: tb/tb_doodle_motion_controller.sv
// Bench for doodle_motion_controller: directed scenarios plus randomized steps
// checked against a phase/ticks-remaining reference model.
module tb_doodle_motion_controller;

   localparam int unsigned W  = 400;
   localparam int unsigned S  = 4;
   localparam int unsigned JH = 150;
   localparam int unsigned SY = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;

   doodle_motion_controller_if bus();

   doodle_motion_controller #(
      .SCREEN_WIDTH  (400),
      .SCREEN_HEIGHT (700),
      .START_Y       (100),
      .JUMP_HEIGHT   (150),
      .X_STEP        (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: phase 0 = going up, 1 = going down, 2 = game over.
   int unsigned m_x, m_y;
   int          m_phase;
   int          m_rise_left;
   bit          m_landed;

   function automatic void model_reset();
      m_x = W / 2; m_y = SY; m_phase = 0; m_rise_left = JH; m_landed = 0;
   endfunction

   function automatic void model_tick(bit t, bit l, bit r, bit hc, logic [31:0] cy);
      m_landed = 0;
      if (!t || m_phase == 2) return;
      if (r && !l)      m_x = (m_x + S) % W;
      else if (l && !r) m_x = (m_x + W - S) % W;
      if (m_phase == 0) begin
         m_y++;
         m_rise_left--;
         if (m_rise_left == 0) m_phase = 1;
      end else if (hc) begin
         m_y = cy; m_phase = 0; m_rise_left = JH; m_landed = 1;
      end else if (m_y == 0) begin
         m_phase = 2;
      end else begin
         m_y--;
      end
   endfunction

   task automatic step(input bit r, input bit t, input bit l, input bit rt,
                       input bit hc, input logic [31:0] cy);
      @(negedge clk);
      rst = r; bus.tick = t; bus.moveLeft = l; bus.moveRight = rt;
      bus.hasCollide = hc; bus.collisionY = cy;
      @(posedge clk);
      #1;
      if (r) model_reset();
      else   model_tick(t, l, rt, hc, cy);
   endtask

   task automatic test_reset();
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 1, 0, 1, 7);
      total++; if (bus.doodleX !== 32'd200) begin bad++; $display("FAIL reset_x got=%0d exp=200", bus.doodleX); end
      total++; if (bus.doodleY !== 32'd100) begin bad++; $display("FAIL reset_y got=%0d exp=100", bus.doodleY); end
      total++; if ({bus.isFalling, bus.landed, bus.gameOver} !== 3'b000) begin
         bad++; $display("FAIL reset_flags got=%b exp=000", {bus.isFalling, bus.landed, bus.gameOver}); end
   endtask

   task automatic test_rise();
      repeat (149) step(0, 1, 0, 0, 0, 0);
      total++; if (bus.doodleY !== 32'd249 || bus.isFalling !== 1'b0) begin
         bad++; $display("FAIL rise_149 got y=%0d fall=%b exp y=249 fall=0", bus.doodleY, bus.isFalling); end
      step(0, 1, 0, 0, 0, 0);
      total++; if (bus.doodleY !== 32'd250 || bus.isFalling !== 1'b1) begin
         bad++; $display("FAIL rise_150 got y=%0d fall=%b exp y=250 fall=1", bus.doodleY, bus.isFalling); end
   endtask

   task automatic test_landing();
      repeat (199) step(0, 1, 0, 0, 0, 0);
      total++; if (bus.doodleY !== 32'd51) begin bad++; $display("FAIL fall_to_51 got=%0d exp=51", bus.doodleY); end
      step(0, 1, 0, 0, 1, 50);
      total++; if (bus.doodleY !== 32'd50 || bus.landed !== 1'b1 || bus.isFalling !== 1'b0) begin
         bad++; $display("FAIL land got y=%0d landed=%b fall=%b exp y=50 landed=1 fall=0",
                         bus.doodleY, bus.landed, bus.isFalling); end
      step(0, 1, 0, 0, 0, 0);
      total++; if (bus.doodleY !== 32'd51 || bus.landed !== 1'b0) begin
         bad++; $display("FAIL after_land got y=%0d landed=%b exp y=51 landed=0", bus.doodleY, bus.landed); end
   endtask

   task automatic test_x_wrap();
      step(1, 0, 0, 0, 0, 0);
      repeat (49) step(0, 1, 0, 1, 0, 0);
      total++; if (bus.doodleX !== 32'd396) begin bad++; $display("FAIL x_right got=%0d exp=396", bus.doodleX); end
      step(0, 1, 0, 1, 0, 0);
      total++; if (bus.doodleX !== 32'd0) begin bad++; $display("FAIL x_wrap_right got=%0d exp=0", bus.doodleX); end
      step(0, 1, 1, 0, 0, 0);
      total++; if (bus.doodleX !== 32'd396) begin bad++; $display("FAIL x_wrap_left got=%0d exp=396", bus.doodleX); end
      step(0, 1, 1, 1, 0, 0);
      total++; if (bus.doodleX !== 32'd396) begin bad++; $display("FAIL x_both got=%0d exp=396", bus.doodleX); end
      step(0, 1, 1, 0, 0, 0);
      total++; if (bus.doodleX !== 32'd392) begin bad++; $display("FAIL x_left got=%0d exp=392", bus.doodleX); end
   endtask

   task automatic test_dead();
      step(1, 0, 0, 0, 0, 0);
      repeat (150 + 247) step(0, 1, 0, 0, 0, 0);
      total++; if (bus.doodleY !== 32'd3) begin bad++; $display("FAIL dead_y3 got=%0d exp=3", bus.doodleY); end
      repeat (3) step(0, 1, 0, 0, 0, 0);
      total++; if (bus.doodleY !== 32'd0 || bus.gameOver !== 1'b0 || bus.isFalling !== 1'b1) begin
         bad++; $display("FAIL dead_y0 got y=%0d go=%b exp y=0 go=0", bus.doodleY, bus.gameOver); end
      step(0, 1, 0, 0, 0, 0);
      total++; if (bus.gameOver !== 1'b1 || bus.doodleY !== 32'd0 || bus.isFalling !== 1'b0) begin
         bad++; $display("FAIL dead_enter got go=%b y=%0d exp go=1 y=0", bus.gameOver, bus.doodleY); end
      repeat (5) step(0, 1, 0, 1, 1, 77);
      total++; if (bus.gameOver !== 1'b1 || bus.doodleY !== 32'd0 || bus.doodleX !== 32'd200 || bus.landed !== 1'b0) begin
         bad++; $display("FAIL dead_frozen got go=%b x=%0d y=%0d landed=%b exp go=1 x=200 y=0 landed=0",
                         bus.gameOver, bus.doodleX, bus.doodleY, bus.landed); end
      step(1, 0, 0, 0, 0, 0);
      total++; if (bus.doodleX !== 32'd200 || bus.doodleY !== 32'd100 || bus.gameOver !== 1'b0) begin
         bad++; $display("FAIL dead_rst got x=%0d y=%0d go=%b exp x=200 y=100 go=0",
                         bus.doodleX, bus.doodleY, bus.gameOver); end
   endtask

   task automatic test_rise_collide_and_hold();
      step(1, 0, 0, 0, 0, 0);
      repeat (10) step(0, 1, 0, 0, 1, 5);
      total++; if (bus.doodleY !== 32'd110 || bus.landed !== 1'b0 || bus.isFalling !== 1'b0) begin
         bad++; $display("FAIL rise_collide got y=%0d landed=%b exp y=110 landed=0", bus.doodleY, bus.landed); end
      repeat (140) step(0, 1, 0, 0, 0, 0);
      repeat (5) step(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'd9);
         total++; if (bus.doodleY !== 32'd245 || bus.doodleX !== 32'd180 || bus.isFalling !== 1'b1 || bus.landed !== 1'b0) begin
            bad++; $display("FAIL tick_low_hold got x=%0d y=%0d fall=%b exp x=180 y=245 fall=1",
                            bus.doodleX, bus.doodleY, bus.isFalling); end
      end
      step(0, 1, 0, 0, 0, 0);
      total++; if (bus.doodleY !== 32'd244) begin bad++; $display("FAIL resume_fall got=%0d exp=244", bus.doodleY); end
   endtask

   task automatic test_rst_mid_fall();
      step(1, 1, 0, 1, 1, 50);
      total++; if (bus.doodleX !== 32'd200 || bus.doodleY !== 32'd100 || bus.landed !== 1'b0 ||
                   bus.isFalling !== 1'b0 || bus.gameOver !== 1'b0) begin
         bad++; $display("FAIL rst_mid_fall got x=%0d y=%0d landed=%b fall=%b go=%b exp x=200 y=100 0 0 0",
                         bus.doodleX, bus.doodleY, bus.landed, bus.isFalling, bus.gameOver); end
   endtask

   task automatic test_random();
      bit r, t, l, rt, hc;
      logic [31:0] cy;
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 499) == 0);
         t  = ($urandom_range(0, 9) < 7);
         l  = 1'($urandom_range(0, 1));
         rt = 1'($urandom_range(0, 1));
         hc = ($urandom_range(0, 29) == 0);
         cy = 32'($urandom_range(0, 300));
         step(r, t, l, rt, hc, cy);
         total++; if (bus.doodleX !== m_x) begin bad++; $display("FAIL rand_x cyc=%0d got=%0d exp=%0d", i, bus.doodleX, m_x); end
         total++; if (bus.doodleY !== m_y) begin bad++; $display("FAIL rand_y cyc=%0d got=%0d exp=%0d", i, bus.doodleY, m_y); end
         total++; if (bus.isFalling !== (m_phase == 1)) begin
            bad++; $display("FAIL rand_fall cyc=%0d got=%b exp=%b", i, bus.isFalling, (m_phase == 1)); end
         total++; if (bus.gameOver !== (m_phase == 2)) begin
            bad++; $display("FAIL rand_over cyc=%0d got=%b exp=%b", i, bus.gameOver, (m_phase == 2)); end
         total++; if (bus.landed !== m_landed) begin
            bad++; $display("FAIL rand_landed cyc=%0d got=%b exp=%b", i, bus.landed, m_landed); end
      end
   endtask

   initial begin
      bus.tick = 1'b0; bus.moveLeft = 1'b0; bus.moveRight = 1'b0;
      bus.hasCollide = 1'b0; bus.collisionY = '0;
      model_reset();
      test_reset();
      test_rise();
      test_landing();
      test_x_wrap();
      test_dead();
      test_rise_collide_and_hold();
      test_rst_mid_fall();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
